// File: rtl/button_event_arbiter.sv
// button_event_arbiter: turns debounced button press edges into a stream of
// single events, one per button press, served round-robin to a consumer
// through a valid/ready handshake. Presses that arrive while the same button
// still has an unserved event are merged into it and flagged in a sticky
// overflow bit.
module button_event_arbiter #(
    parameter int unsigned N_BTN = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_BTN-1:0]  btn,
    input  logic              evt_ready,
    input  logic              clr_overflow,
    output logic              evt_valid,
    output logic [ID_W-1:0]   evt_id,
    output logic [N_BTN-1:0]  pending,
    output logic [N_BTN-1:0]  overflow,
    output logic [15:0]       evt_count
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t            state;
    logic [N_BTN-1:0]  btn_q;
    logic [N_BTN-1:0]  rise;
    logic [N_BTN-1:0]  acc_vec;
    logic [N_BTN-1:0]  pend_nxt;
    logic [N_BTN-1:0]  ovf_set;
    logic [N_BTN-1:0]  ovf_nxt;
    logic [ID_W-1:0]   last_grant;
    logic [ID_W-1:0]   rr_winner;
    logic [ID_W-1:0]   cand;
    logic              found;
    logic              accept;

    // Press edges, handshake, and per-button accept decode.
    always_comb begin
        rise    = btn & ~btn_q;
        accept  = (state == PRESENT) && evt_ready;
        acc_vec = '0;
        for (int unsigned i = 0; i < N_BTN; i++) begin
            acc_vec[i] = accept && (evt_id == ID_W'(i));
        end
    end

    // Pending/overflow next state: a press coinciding with the accept of the
    // same button re-arms pending without counting as a lost press.
    always_comb begin
        pend_nxt = '0;
        ovf_set  = '0;
        for (int unsigned i = 0; i < N_BTN; i++) begin
            pend_nxt[i] = rise[i] | (pending[i] & ~acc_vec[i]);
            ovf_set[i]  = rise[i] & pending[i] & ~acc_vec[i];
        end
        ovf_nxt = (clr_overflow ? '0 : overflow) | ovf_set;
    end

    // Round-robin search: first pending bit upward from last_grant+1, wrapping.
    // The candidate walks with an explicit wrap so non-power-of-two N_BTN works.
    always_comb begin
        rr_winner = '0;
        found     = 1'b0;
        cand      = (last_grant == ID_W'(N_BTN - 1)) ? '0 : last_grant + ID_W'(1);
        for (int unsigned k = 0; k < N_BTN; k++) begin
            if (!found && pending[cand]) begin
                found     = 1'b1;
                rr_winner = cand;
            end
            cand = (cand == ID_W'(N_BTN - 1)) ? '0 : cand + ID_W'(1);
        end
    end

    // Edge-detect history and per-button pending/overflow flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            btn_q    <= '1;
            pending  <= '0;
            overflow <= '0;
        end else begin
            btn_q    <= btn;
            pending  <= pend_nxt;
            overflow <= ovf_nxt;
        end
    end

    // Presentation FSM with registered evt_valid/evt_id, grant history and
    // accepted-event counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            evt_valid  <= 1'b0;
            evt_id     <= '0;
            last_grant <= ID_W'(N_BTN - 1);
            evt_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|pending) begin
                        evt_id    <= rr_winner;
                        evt_valid <= 1'b1;
                        state     <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (evt_ready) begin
                        last_grant <= evt_id;
                        evt_valid  <= 1'b0;
                        evt_count  <= evt_count + 16'd1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    evt_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter: a table of per-cycle inputs with
// hand-computed outputs, followed by hand-written multi-cycle sequences for
// reset mid-presentation, counter wrap and overflow set/clear collision.
module tb_button_event_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  btn;
    logic        evt_ready;
    logic        clr_overflow;
    logic        evt_valid;
    logic [1:0]  evt_id;
    logic [3:0]  pending;
    logic [3:0]  overflow;
    logic [15:0] evt_count;

    int checks = 0;
    int passed = 0;

    button_event_arbiter #(
        .N_BTN(4),
        .ID_W (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn         (btn),
        .evt_ready   (evt_ready),
        .clr_overflow(clr_overflow),
        .evt_valid   (evt_valid),
        .evt_id      (evt_id),
        .pending     (pending),
        .overflow    (overflow),
        .evt_count   (evt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  b;
        logic        rdy;
        logic        clr;
        logic        v;
        logic [1:0]  id;
        logic [3:0]  p;
        logic [3:0]  o;
        logic [15:0] c;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic [3:0] b, input logic rdy,
                                input logic clr, input logic v, input logic [1:0] id,
                                input logic [3:0] p, input logic [3:0] o, input logic [15:0] c);
        vec_t r;
        r.rst = rst; r.b = b; r.rdy = rdy; r.clr = clr;
        r.v = v; r.id = id; r.p = p; r.o = o; r.c = c;
        return r;
    endfunction

    task automatic drive(input logic r, input logic [3:0] b, input logic rd, input logic c);
        reset        = r;
        btn          = b;
        evt_ready    = rd;
        clr_overflow = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] pack_out();
        return {5'd0, evt_valid, evt_id, pending, overflow, evt_count};
    endfunction

    initial begin
        drive(1'b0, 4'b0000, 1'b0, 1'b0);

        //              rst btn      rdy clr   v  id  pending  overflow  count
        tbl.push_back(mk(0, 4'b0000, 0, 0,   0, 0, 4'b0000, 4'b0000, 16'd0)); // reset state
        tbl.push_back(mk(1, 4'b0000, 1, 0,   0, 0, 4'b0000, 4'b0000, 16'd0));
        // single press
        tbl.push_back(mk(1, 4'b0001, 1, 0,   0, 0, 4'b0001, 4'b0000, 16'd0));
        tbl.push_back(mk(1, 4'b0001, 1, 0,   1, 0, 4'b0001, 4'b0000, 16'd0));
        tbl.push_back(mk(1, 4'b0001, 1, 0,   0, 0, 4'b0000, 4'b0000, 16'd1));
        // reset again so the simultaneous press starts from last_grant = 3
        tbl.push_back(mk(0, 4'b0000, 1, 0,   0, 0, 4'b0000, 4'b0000, 16'd0));
        tbl.push_back(mk(1, 4'b0000, 1, 0,   0, 0, 4'b0000, 4'b0000, 16'd0));
        // simultaneous press: ids 0,1,2,3
        tbl.push_back(mk(1, 4'b1111, 1, 0,   0, 0, 4'b1111, 4'b0000, 16'd0));
        tbl.push_back(mk(1, 4'b1111, 1, 0,   1, 0, 4'b1111, 4'b0000, 16'd0));
        tbl.push_back(mk(1, 4'b1111, 1, 0,   0, 0, 4'b1110, 4'b0000, 16'd1));
        tbl.push_back(mk(1, 4'b1111, 1, 0,   1, 1, 4'b1110, 4'b0000, 16'd1));
        tbl.push_back(mk(1, 4'b1111, 1, 0,   0, 1, 4'b1100, 4'b0000, 16'd2));
        tbl.push_back(mk(1, 4'b1111, 1, 0,   1, 2, 4'b1100, 4'b0000, 16'd2));
        tbl.push_back(mk(1, 4'b1111, 1, 0,   0, 2, 4'b1000, 4'b0000, 16'd3));
        tbl.push_back(mk(1, 4'b1111, 1, 0,   1, 3, 4'b1000, 4'b0000, 16'd3));
        tbl.push_back(mk(1, 4'b1111, 1, 0,   0, 3, 4'b0000, 4'b0000, 16'd4));
        tbl.push_back(mk(1, 4'b0000, 1, 0,   0, 3, 4'b0000, 4'b0000, 16'd4));
        // backpressure + overflow on button 2
        tbl.push_back(mk(1, 4'b0100, 0, 0,   0, 3, 4'b0100, 4'b0000, 16'd4));
        tbl.push_back(mk(1, 4'b0000, 0, 0,   1, 2, 4'b0100, 4'b0000, 16'd4));
        tbl.push_back(mk(1, 4'b0100, 0, 0,   1, 2, 4'b0100, 4'b0100, 16'd4));
        tbl.push_back(mk(1, 4'b0100, 0, 0,   1, 2, 4'b0100, 4'b0100, 16'd4));
        tbl.push_back(mk(1, 4'b0000, 1, 0,   0, 2, 4'b0000, 4'b0100, 16'd5));
        tbl.push_back(mk(1, 4'b0000, 1, 0,   0, 2, 4'b0000, 4'b0100, 16'd5));
        tbl.push_back(mk(1, 4'b0000, 1, 1,   0, 2, 4'b0000, 4'b0000, 16'd5));
        // serve button 1 so last_grant = 1
        tbl.push_back(mk(1, 4'b0010, 1, 0,   0, 2, 4'b0010, 4'b0000, 16'd5));
        tbl.push_back(mk(1, 4'b0010, 1, 0,   1, 1, 4'b0010, 4'b0000, 16'd5));
        tbl.push_back(mk(1, 4'b0010, 1, 0,   0, 1, 4'b0000, 4'b0000, 16'd6));
        tbl.push_back(mk(1, 4'b0000, 1, 0,   0, 1, 4'b0000, 4'b0000, 16'd6));
        // fairness: pending 1011 with last_grant 1 -> 3,0,1; held buttons give nothing more
        tbl.push_back(mk(1, 4'b1011, 1, 0,   0, 1, 4'b1011, 4'b0000, 16'd6));
        tbl.push_back(mk(1, 4'b1011, 1, 0,   1, 3, 4'b1011, 4'b0000, 16'd6));
        tbl.push_back(mk(1, 4'b1011, 1, 0,   0, 3, 4'b0011, 4'b0000, 16'd7));
        tbl.push_back(mk(1, 4'b1011, 1, 0,   1, 0, 4'b0011, 4'b0000, 16'd7));
        tbl.push_back(mk(1, 4'b1011, 1, 0,   0, 0, 4'b0010, 4'b0000, 16'd8));
        tbl.push_back(mk(1, 4'b1011, 1, 0,   1, 1, 4'b0010, 4'b0000, 16'd8));
        tbl.push_back(mk(1, 4'b1011, 1, 0,   0, 1, 4'b0000, 4'b0000, 16'd9));
        tbl.push_back(mk(1, 4'b1011, 1, 0,   0, 1, 4'b0000, 4'b0000, 16'd9));
        tbl.push_back(mk(1, 4'b0000, 1, 0,   0, 1, 4'b0000, 4'b0000, 16'd9));

        #2;
        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].b, tbl[i].rdy, tbl[i].clr);
            tick();
            chk($sformatf("vec%0d {v,id,pend,ovf,cnt}", i), pack_out(),
                {5'd0, tbl[i].v, tbl[i].id, tbl[i].p, tbl[i].o, tbl[i].c});
        end

        // Reset while presenting id 1, then button 1 held through reset.
        drive(1, 4'b0010, 0, 0); tick();
        drive(1, 4'b0010, 0, 0); tick();
        chk("pre_reset_present", {30'd0, evt_valid, evt_id == 2'd1}, 32'd3);
        drive(0, 4'b0010, 1, 0); tick();
        chk("reset_mid_present", pack_out(), 32'd0);
        for (int unsigned k = 0; k < 4; k++) begin
            drive(1, 4'b0010, 1, 0); tick();
            chk($sformatf("held_thru_reset%0d {v,pend,cnt}", k),
                {11'd0, evt_valid, pending, evt_count}, 32'd0);
        end
        drive(1, 4'b0000, 1, 0); tick();
        drive(1, 4'b0010, 1, 0); tick();
        chk("repress_pending", {28'd0, pending}, 32'b0010);
        tick();
        chk("repress_event {v,id}", {29'd0, evt_valid, evt_id}, {29'd0, 1'b1, 2'd1});
        tick();
        chk("repress_accept {v,cnt}", {15'd0, evt_valid, evt_count}, {15'd0, 1'b0, 16'd1});

        // Counter wrap: 65535 accepts from a fresh reset, then one more.
        drive(0, 4'b0000, 1, 0); tick();
        drive(1, 4'b0000, 1, 0); tick();
        for (int unsigned i = 0; i < 131070; i++) begin
            drive(1, (i % 2 == 0) ? 4'b0001 : 4'b0000, 1, 0);
            tick();
        end
        drive(1, 4'b0000, 1, 0); tick();
        chk("count_ffff", {16'd0, evt_count}, 32'h0000_FFFF);
        chk("idle_after_bulk {v,pend,ovf}", {23'd0, evt_valid, pending, overflow}, 32'd0);
        drive(1, 4'b0001, 1, 0); tick();
        drive(1, 4'b0000, 1, 0); tick();
        drive(1, 4'b0000, 1, 0); tick();
        chk("count_wrap {v,cnt}", {15'd0, evt_valid, evt_count}, 32'd0);

        // clr_overflow colliding with a new overflow on bit 3: the set wins.
        drive(1, 4'b1000, 0, 0); tick();
        drive(1, 4'b0000, 0, 0); tick();
        chk("present_id3 {v,id}", {29'd0, evt_valid, evt_id}, {29'd0, 1'b1, 2'd3});
        drive(1, 4'b1000, 0, 1); tick();
        chk("clr_vs_set {pend,ovf}", {24'd0, pending, overflow}, {24'd0, 4'b1000, 4'b1000});
        drive(1, 4'b0000, 1, 0); tick();
        chk("drain {v,ovf,cnt}", {11'd0, evt_valid, overflow, evt_count},
            {11'd0, 1'b0, 4'b1000, 16'd1});

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/button_event_arbiter.md
BUTTON_EVENT_ARBITER -- requirements
Module: button_event_arbiter

Interface
REQ-001 The block SHALL have parameter N_BTN, default 4, meaning the number of debounced button inputs (legal values 2..16).
REQ-002 The block SHALL have parameter ID_W, default 2, meaning the event index width, equal to ceil(log2(N_BTN)).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port btn, input, N_BTN bits: debounced button levels, synchronous to clk, 1 = pressed.
REQ-006 The block SHALL have port evt_ready, input, 1 bit: the consumer accepts the presented event.
REQ-007 The block SHALL have port clr_overflow, input, 1 bit: single-cycle clear of all overflow bits.
REQ-008 The block SHALL have port evt_valid, output, 1 bit: an event is presented.
REQ-009 The block SHALL have port evt_id, output, ID_W bits: index of the button owning the presented event.
REQ-010 The block SHALL have port pending, output, N_BTN bits: per-button unserved press flags.
REQ-011 The block SHALL have port overflow, output, N_BTN bits: sticky per-button lost-press flags.
REQ-012 The block SHALL have port evt_count, output, 16 bits: total accepted events.

Function
REQ-013 The block SHALL register btn each cycle as btn_q; a press edge on bit i SHALL be detected as rise[i] = btn[i] & ~btn_q[i].
REQ-014 On rise[i], pending[i] SHALL be 1 after the same edge.
REQ-015 An accept SHALL be defined as evt_valid & evt_ready at a rising clk edge; an accept SHALL clear pending[evt_id].
REQ-016 If rise[i] coincides with an accept of id i, pending[i] SHALL remain 1 and overflow[i] SHALL NOT be set.
REQ-017 If rise[i] occurs while pending[i] = 1 and no accept of id i occurs in that cycle, overflow[i] SHALL be set, pending[i] SHALL remain 1, and the presses SHALL merge into one event.
REQ-018 clr_overflow SHALL clear every overflow bit; in the same cycle, a set on bit i SHALL win over the clear.
REQ-019 Control SHALL be a two-state FSM with states IDLE and PRESENT; evt_valid SHALL be 1 exactly when the FSM is in PRESENT.
REQ-020 In IDLE with pending != 0, the FSM SHALL load evt_id with the round-robin winner and move to PRESENT; in IDLE with pending == 0, it SHALL stay in IDLE.
REQ-021 The round-robin winner SHALL be the first set pending bit searched upward from (last_grant+1) mod N_BTN, wrapping.
REQ-022 In PRESENT without evt_ready, evt_id and evt_valid SHALL hold stable.
REQ-023 In PRESENT on an accept, the FSM SHALL set last_grant to evt_id and return to IDLE, giving at most one event per 2 cycles.
REQ-024 Latency SHALL be 2 edges: a btn bit first sampled high at edge k, with the FSM in IDLE and no other pending bit, SHALL give evt_valid = 1 after edge k+1.
REQ-025 On each accept, evt_count SHALL increment by 1, wrapping from 0xFFFF to 0x0000.
REQ-026 A button held continuously SHALL generate exactly one event until it is released and pressed again.

Reset
REQ-027 When reset = 0 at a rising edge, the block SHALL set FSM = IDLE, evt_valid = 0, evt_id = 0, pending = 0, overflow = 0, evt_count = 0, last_grant = N_BTN-1, and btn_q = all ones.
REQ-028 While reset = 0, btn and evt_ready SHALL be ignored, including during PRESENT: the presented event SHALL be dropped without counting.
REQ-029 Because btn_q resets to all ones, a button held through reset SHALL produce no event until it is released and re-pressed.

Verification
REQ-030 The bench SHALL cover single press: btn = 0001 at edge k, evt_ready = 1 -> evt_valid = 1, evt_id = 0 after edge k+1; after the next edge, evt_valid = 0, pending = 0000, evt_count = 1.
REQ-031 The bench SHALL cover a simultaneous press: btn 0000 -> 1111 in one cycle, evt_ready = 1 -> evt_id sequence 0,1,2,3, each valid for 1 cycle with 1 idle cycle between; then evt_count = 4 and overflow = 0000.
REQ-032 The bench SHALL cover backpressure and overflow: evt_ready = 0, press btn[2], release, press again -> evt_id = 2 held stable, overflow = 0100; then evt_ready = 1 -> exactly one event is accepted and pending = 0000.
REQ-033 The bench SHALL cover fairness: with last_grant = 1 and pending = 1011 -> evt_id order 3, 0, 1.
REQ-034 The bench SHALL cover reset mid-operation: reset = 0 for 1 cycle while in PRESENT with evt_id = 1 -> all outputs 0 next edge; btn[1] held through reset produces no event; a release and re-press gives evt_id = 1.
REQ-035 The bench SHALL cover counter wrap and clear: preload evt_count to 0xFFFF via 65535 accepts, then 1 accept -> evt_count = 0x0000; clr_overflow coinciding with a new overflow on bit 3 -> overflow = 1000.
